// File: rtl/fsm_rr_arbiter.sv
// Three-requester round-robin arbiter with a bounded hold time.
// A grant that outlives MAX_HOLD cycles is revoked and counted as a timeout.
module fsm_rr_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    GAP   = 2'b10
  } state_t;

  // Plain vector so the illegal code 2'b11 stays representable.
  logic [1:0] state;
  state_t     state_nxt;

  logic [1:0] owner;
  logic [1:0] last;
  logic [7:0] hold_cnt;

  logic       grant_en;
  logic       tmo;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;

  // Priority order: last+1, last+2, then last itself.
  always_comb begin
    win   = 2'd0;
    cand  = 2'd0;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand = 2'((int'(last) + k) % 3);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = IDLE;
    grant_en  = 1'b0;
    tmo       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          grant_en  = 1'b1;
        end
      end
      GRANT: begin
        // Release takes precedence over a coincident timeout.
        if (!req[owner]) begin
          state_nxt = GAP;
        end else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
          state_nxt = GAP;
          tmo       = 1'b1;
        end else begin
          state_nxt = GRANT;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 2'd0;
      last        <= 2'd2;
      hold_cnt    <= 8'd0;
      timeout_err <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_nxt;
      timeout_err <= tmo;
      if (grant_en) begin
        owner    <= win;
        last     <= win;
        hold_cnt <= 8'd0;
      end else if (state == GRANT) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
      if (tmo && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end

  // Grant is decoded from the state flop, so reset clears it without a clock.
  assign gnt    = (state == GRANT) ? (3'b001 << owner) : 3'b000;
  assign gnt_id = (state == GRANT) ? owner : 2'd0;
  assign busy   = |gnt;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed bench for fsm_rr_arbiter built with MAX_HOLD=4; expected values
// are worked out by hand from the cycle-level behaviour of the arbiter.
module tb_fsm_rr_arbiter;

  localparam int MH = 4;

  logic       clk;
  logic       reset_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout_err;
  logic [7:0] err_count;

  int errors = 0;
  int checks = 0;

  fsm_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .gnt         (gnt),
    .gnt_id      (gnt_id),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant integrity on every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      checks++;
      assert ($onehot0(gnt) && (busy === (gnt != 3'b000)) &&
              (gnt != 3'b000 || gnt_id === 2'd0)) else begin
        errors++;
        $error("FAIL onehot: gnt=%b gnt_id=%0d busy=%b", gnt, gnt_id, busy);
      end
    end
  end

  initial begin
    int ids[4];
    ids = '{0, 1, 2, 0};
    reset_n = 1'b0;
    req     = 3'b000;
    #12;
    chk("rst_gnt",    32'(gnt), 0);
    chk("rst_gnt_id", 32'(gnt_id), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_tmo",    32'(timeout_err), 0);
    chk("rst_errcnt", 32'(err_count), 0);
    chk("rst_state",  32'(dut.state), 0);
    chk("rst_last",   32'(dut.last), 2);
    chk("rst_hold",   32'(dut.hold_cnt), 0);
    reset_n = 1'b1;
    tick();

    // Single requester, voluntary release after 4 grant cycles.
    req = 3'b010;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rel_gnt", 32'(gnt), 2);
      chk("rel_id",  32'(gnt_id), 1);
      if (i == 4) req = 3'b000;
    end
    tick();
    chk("rel_gap_gnt", 32'(gnt), 0);
    chk("rel_gap_tmo", 32'(timeout_err), 0);
    chk("rel_gap_st",  32'(dut.state), 2);
    tick();
    chk("rel_idle_st", 32'(dut.state), 0);
    chk("rel_errcnt",  32'(err_count), 0);

    // Fresh reset, then all three requesting: timeouts rotate 0,1,2,0.
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1 << ids[k]));
      chk("rr_id",  32'(gnt_id), 32'(ids[k]));
      for (int j = 1; j < MH; j++) begin
        tick();
        chk("rr_hold_gnt", 32'(gnt), 32'(1 << ids[k]));
        chk("rr_hold_tmo", 32'(timeout_err), 0);
      end
      tick();
      chk("rr_gap_gnt", 32'(gnt), 0);
      chk("rr_tmo",     32'(timeout_err), 1);
      chk("rr_errcnt",  32'(err_count), 32'(k + 1));
      tick();
      chk("rr_tmo_pulse", 32'(timeout_err), 0);
      chk("rr_idle_gnt",  32'(gnt), 0);
    end
    req = 3'b000;
    tick();

    // Release in the same cycle the hold limit is reached.
    req = 3'b001;
    tick();
    chk("edge_gnt", 32'(gnt), 1);
    tick();
    tick();
    tick();
    chk("edge_hold", 32'(dut.hold_cnt), 3);
    req = 3'b000;
    tick();
    chk("edge_gnt0",   32'(gnt), 0);
    chk("edge_tmo",    32'(timeout_err), 0);
    chk("edge_errcnt", 32'(err_count), 4);
    tick();

    // Non-owner request changes are ignored while granted.
    req = 3'b100;
    tick();
    chk("ign_gnt0", 32'(gnt), 4);
    req = 3'b110;
    tick();
    chk("ign_gnt1", 32'(gnt), 4);
    req = 3'b101;
    tick();
    chk("ign_gnt2", 32'(gnt), 4);
    req = 3'b000;
    tick();
    chk("ign_rel", 32'(gnt), 0);
    tick();

    // Asynchronous reset mid-grant, then lowest index wins.
    req = 3'b010;
    tick();
    chk("ar_gnt", 32'(gnt), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_gnt0",  32'(gnt), 0);
    chk("ar_busy",  32'(busy), 0);
    chk("ar_last",  32'(dut.last), 2);
    chk("ar_errcnt", 32'(err_count), 0);
    #1;
    reset_n = 1'b1;
    req = 3'b011;
    tick();
    chk("ar_post_gnt", 32'(gnt), 1);
    chk("ar_post_id",  32'(gnt_id), 0);
    req = 3'b000;
    tick();
    tick();

    // Illegal state code falls back to IDLE with no grant.
    req = 3'b100;
    tick();
    chk("ill_pre_gnt", 32'(gnt), 4);
    @(negedge clk);
    force dut.state = 2'b11;
    req = 3'b000;
    #1;
    chk("ill_gnt",  32'(gnt), 0);
    chk("ill_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    release dut.state;
    tick();
    chk("ill_state", 32'(dut.state), 0);
    chk("ill_gnt2",  32'(gnt), 0);

    // Repeated forced timeouts: one per 6 cycles, saturating at 255.
    req = 3'b001;
    repeat (200 * (MH + 2)) tick();
    chk("sat_200", 32'(err_count), 200);
    repeat (60 * (MH + 2)) tick();
    chk("sat_255", 32'(err_count), 255);
    repeat (3 * (MH + 2)) tick();
    chk("sat_hold", 32'(err_count), 255);
    req = 3'b000;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_rr_arbiter.md
FSM_RR_ARBITER -- requirements
Module: fsm_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of cycles one grant SHALL be held, legal range 2..255.
REQ-002 Port clk, input, 1 bit, is the system clock; all state SHALL update on its rising edge.
REQ-003 Port reset_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-004 Port req, input, 3 bits, is the request vector; bit i SHALL mean requester i wants the shared resource.
REQ-005 Port gnt, output, 3 bits, is the registered grant; it SHALL be one-hot or zero.
REQ-006 Port gnt_id, output, 2 bits, SHALL carry the binary index of the current owner, and SHALL be 0 when gnt is 0.
REQ-007 Port busy, output, 1 bit, SHALL be high whenever gnt is nonzero.
REQ-008 Port timeout_err, output, 1 bit, SHALL be a one-cycle pulse on forced revocation.
REQ-009 Port err_count, output, 8 bits, SHALL be a saturating count of timeouts.

Function
REQ-010 The FSM SHALL be 2-bit binary encoded: IDLE=00, GRANT=01, GAP=10; code 11 SHALL return to IDLE on the next cycle with gnt=0.
REQ-011 IDLE with req==0 SHALL stay in IDLE, with gnt=0.
REQ-012 IDLE with req!=0 SHALL select a winner by round-robin, then on the next edge enter GRANT with gnt=onehot(winner), gnt_id=winner, and hold_cnt=0; grant latency SHALL be 1 cycle.
REQ-013 Round-robin priority order SHALL be (last+1) mod 3, (last+2) mod 3, last, where last is the most recently granted index.
REQ-014 last SHALL update to the winner on grant entry.
REQ-015 In GRANT, hold_cnt SHALL increment by 1 each cycle, 8 bits wide, with no wrap before MAX_HOLD.
REQ-016 GRANT with req[owner]==0 SHALL release: the next edge enters GAP with gnt=0.
REQ-017 GRANT with req[owner]==1 and hold_cnt==MAX_HOLD-1 SHALL force a timeout on the next edge:
- enter GAP with gnt=0;
- timeout_err=1 for exactly that one cycle;
- err_count incremented, saturating at 255.
REQ-018 If release and timeout coincide in the same cycle, release SHALL win: no timeout_err and no err_count change.
REQ-019 Changes on req bits other than the owner's SHALL NOT affect GRANT.
REQ-020 GAP SHALL last exactly one cycle with gnt=0 and then return to IDLE; req SHALL be ignored during GAP.
REQ-021 Minimum spacing between two consecutive grants SHALL be 3 cycles: release, GAP, then IDLE arbitration.
REQ-022 gnt SHALL never have more than one bit set in any cycle, including across the cycles of a transition.
REQ-023 A requester revoked by timeout that still requests SHALL compete normally, at lowest priority.

Reset
REQ-024 While reset_n=0, the block SHALL immediately hold: state=IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, err_count=0, hold_cnt=0, last=2.
REQ-025 Assertion of reset_n during GRANT SHALL clear gnt asynchronously, without waiting for a clock edge.
REQ-026 After reset deassertion, the first arbitration SHALL give requester 0 top priority.

Verification
REQ-027 Scenario: reset, then req=3'b111 held -> grant sequence 0,1,2,0; each grant lasts MAX_HOLD cycles with timeout_err pulses; err_count increments per timeout.
REQ-028 Scenario: req=3'b010 for 4 cycles, then 0 -> gnt=3'b010 from cycle 1 for 4 cycles; GAP; IDLE; timeout_err never asserted.
REQ-029 Scenario: MAX_HOLD=4 with req[0] dropped exactly in the cycle hold_cnt==3 -> clean release with no timeout_err and err_count unchanged.
REQ-030 Scenario: reset_n pulsed low mid-GRANT, asynchronous to clk -> gnt=0 before the next edge; the post-reset grant goes to the lowest requesting index.
REQ-031 Scenario: 260 forced timeouts with MAX_HOLD=2 -> err_count saturates at 255 and stays there.
REQ-032 Scenario: force the state register to 11 -> the next cycle is IDLE with gnt=0; a one-hot assertion on gnt SHALL hold throughout all scenarios.
